// File: rtl/axi_line_master.sv
// Cache-line AXI4 master: each accepted line request becomes one INCR burst
// (AW/W/B or AR/R) and ends in a single response pulse with refill data and error flag.
module axi_line_master #(
  parameter int              ADDR_W = 32,
  parameter int              DATA_W = 32,
  parameter int              BEATS  = 4,
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [ADDR_W-1:0]       req_addr_i,
  input  logic [BEATS*DATA_W-1:0] req_wdata_i,
  output logic                    resp_valid_o,
  output logic                    resp_err_o,
  output logic [BEATS*DATA_W-1:0] resp_rdata_o,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [ADDR_W-1:0]       m_axi_awaddr,
  output logic [ID_W-1:0]         m_axi_awid,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  output logic [DATA_W-1:0]       m_axi_wdata,
  output logic [DATA_W/8-1:0]     m_axi_wstrb,
  output logic                    m_axi_wlast,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  input  logic [1:0]              m_axi_bresp,
  input  logic [ID_W-1:0]         m_axi_bid,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  output logic [ADDR_W-1:0]       m_axi_araddr,
  output logic [ID_W-1:0]         m_axi_arid,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic [DATA_W-1:0]       m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic [ID_W-1:0]         m_axi_rid,
  input  logic                    m_axi_rlast
);

  // state | meaning
  // IDLE  | waiting for a line request, req_ready_o high
  // AW    | write address presented until awready
  // W     | streaming write beats, wlast on the final beat
  // B     | waiting for the write response
  // AR    | read address presented until arready
  // R     | collecting read beats into the line buffer
  // RESP  | one-cycle completion pulse
  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_RESP} state_t;

  localparam int LINE_W = BEATS * DATA_W;
  localparam int CNT_W  = $clog2(BEATS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_W / 8 - 1);

  state_t              state_q, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   line_q;
  logic [LINE_W-1:0]   line_merge;
  logic [LINE_W-1:0]   rdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                err_q;
  logic                cnt_last;
  logic                r_err;
  logic                r_exit;

  assign cnt_last = (cnt_q == CNT_LAST);
  assign r_err    = (m_axi_rresp != 2'b00) | (m_axi_rid != AXI_ID) | (m_axi_rlast != cnt_last);
  assign r_exit   = m_axi_rlast | cnt_last;

  always_comb begin
    line_merge = line_q;
    line_merge[int'(cnt_q)*DATA_W +: DATA_W] = m_axi_rdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: if (req_valid_i) state_nxt = req_we_i ? S_AW : S_AR;
      S_AW:   if (m_axi_awready) state_nxt = S_W;
      S_W:    if (m_axi_wready && cnt_last) state_nxt = S_B;
      S_B:    if (m_axi_bvalid) state_nxt = S_RESP;
      S_AR:   if (m_axi_arready) state_nxt = S_R;
      S_R:    if (m_axi_rvalid && r_exit) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o   = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    resp_valid_o  = 1'b0;
    case (state_q)
      S_IDLE: req_ready_o   = 1'b1;
      S_AW:   m_axi_awvalid = 1'b1;
      S_W:    m_axi_wvalid  = 1'b1;
      S_B:    m_axi_bready  = 1'b1;
      S_AR:   m_axi_arvalid = 1'b1;
      S_R:    m_axi_rready  = 1'b1;
      S_RESP: resp_valid_o  = 1'b1;
      default: ;
    endcase
  end

  // The line buffer doubles as write source and read assembly area; the
  // response register is only updated on the final read beat so it holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid_i) begin
          addr_q <= req_addr_i & ~OFF_MASK;
          line_q <= req_wdata_i;
          cnt_q  <= '0;
          err_q  <= 1'b0;
        end
        S_W: if (m_axi_wready) cnt_q <= cnt_q + 1'b1;
        S_B: if (m_axi_bvalid) err_q <= err_q | (m_axi_bresp != 2'b00) | (m_axi_bid != AXI_ID);
        S_R: if (m_axi_rvalid) begin
          line_q <= line_merge;
          err_q  <= err_q | r_err;
          cnt_q  <= cnt_q + 1'b1;
          if (r_exit) rdata_q <= line_merge;
        end
        default: ;
      endcase
    end
  end

  assign resp_err_o    = resp_valid_o & err_q;
  assign resp_rdata_o  = rdata_q;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awid    = AXI_ID;
  assign m_axi_awlen   = 8'(BEATS - 1);
  assign m_axi_awsize  = 3'($clog2(DATA_W / 8));
  assign m_axi_awburst = 2'b01;
  assign m_axi_wdata   = line_q[int'(cnt_q)*DATA_W +: DATA_W];
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = cnt_last;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arid    = AXI_ID;
  assign m_axi_arlen   = 8'(BEATS - 1);
  assign m_axi_arsize  = 3'($clog2(DATA_W / 8));
  assign m_axi_arburst = 2'b01;

endmodule

// File: tb/tb_axi_line_master.sv
// Bench for axi_line_master: a behavioural AXI slave with random stalls and
// error injection, checked against line/beat expectations computed per transaction.
module tb_axi_line_master;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BEATS  = 4;
  localparam int ID_W   = 4;
  localparam int LINE_W = BEATS * DATA_W;
  localparam logic [ID_W-1:0] AXI_ID = 4'd0;

  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic req_valid_i = 0, req_ready_o, req_we_i = 0;
  logic [ADDR_W-1:0] req_addr_i = '0;
  logic [LINE_W-1:0] req_wdata_i = '0, resp_rdata_o;
  logic resp_valid_o, resp_err_o;
  logic m_axi_awvalid, m_axi_awready = 0, m_axi_wvalid, m_axi_wready = 0, m_axi_wlast;
  logic [ADDR_W-1:0] m_axi_awaddr, m_axi_araddr;
  logic [ID_W-1:0] m_axi_awid, m_axi_arid, m_axi_bid = '0, m_axi_rid = '0;
  logic [7:0] m_axi_awlen, m_axi_arlen;
  logic [2:0] m_axi_awsize, m_axi_arsize;
  logic [1:0] m_axi_awburst, m_axi_arburst, m_axi_bresp = '0, m_axi_rresp = '0;
  logic [DATA_W-1:0] m_axi_wdata, m_axi_rdata = '0;
  logic [DATA_W/8-1:0] m_axi_wstrb;
  logic m_axi_bvalid = 0, m_axi_bready, m_axi_arvalid, m_axi_arready = 0;
  logic m_axi_rvalid = 0, m_axi_rready, m_axi_rlast = 0;

  axi_line_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS), .ID_W(ID_W), .AXI_ID(AXI_ID)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_err_o(resp_err_o), .resp_rdata_o(resp_rdata_o),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bid(m_axi_bid),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rid(m_axi_rid), .m_axi_rlast(m_axi_rlast)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  logic [LINE_W-1:0] last_rdata = '0;
  bit last_rd_ok = 1'b1;

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int k = 0; k < BEATS; k++) l[k*DATA_W +: DATA_W] = $urandom;
    return l;
  endfunction

  task automatic clear_slave();
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0;
    m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_bresp = '0; m_axi_rresp = '0;
    m_axi_bid = '0; m_axi_rid = '0; m_axi_rdata = '0;
  endtask

  // One line transaction against the slave model. bad_beat<0: no rresp error;
  // rlast_beat is the read beat that carries rlast; rst_beat>=0 aborts with reset at that W beat.
  task automatic run_txn(input bit we, input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] line,
                         input int stall, input logic [1:0] bresp, input logic [ID_W-1:0] rsp_id,
                         input int bad_beat, input int rlast_beat, input int exp_lat, input int rst_beat);
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] rbeats [BEATS];
    logic [LINE_W-1:0] exp_line;
    bit exp_err, addr_done, data_done, got_resp, done;
    int beat, a_wait, d_wait, cyc, n_acc;
    exp_addr = addr & ~ADDR_W'(LINE_W / 8 - 1);
    for (int k = 0; k < BEATS; k++) begin
      rbeats[k] = $urandom;
      exp_line[k*DATA_W +: DATA_W] = rbeats[k];
    end
    n_acc = (rlast_beat < BEATS - 1) ? rlast_beat + 1 : BEATS;
    if (we) exp_err = (bresp != 2'b00) || (rsp_id != AXI_ID);
    else    exp_err = (rsp_id != AXI_ID) || (rlast_beat != BEATS - 1) || (bad_beat >= 0 && bad_beat < n_acc);
    @(negedge clk_i);
    checks++;
    if (req_ready_o !== 1'b1) begin failures++; $display("FAIL req_ready_idle got=%b exp=1", req_ready_o); end
    req_valid_i = 1; req_we_i = we; req_addr_i = addr; req_wdata_i = line;
    a_wait = $urandom_range(0, stall); d_wait = $urandom_range(0, stall);
    beat = 0; cyc = 0; addr_done = 0; data_done = 0; got_resp = 0; done = 0;
    while (!done && cyc < 400) begin
      @(negedge clk_i); cyc++;
      clear_slave();
      req_valid_i = got_resp ? 1'b0 : 1'($urandom_range(0, 1));
      req_we_i = 1'($urandom); req_addr_i = $urandom; req_wdata_i = rand_line();
      if (got_resp) begin
        checks++;
        if ({resp_valid_o, req_ready_o} !== 2'b01) begin
          failures++; $display("FAIL resp_single_pulse got valid=%b ready=%b exp valid=0 ready=1", resp_valid_o, req_ready_o);
        end
        done = 1;
      end else if (resp_valid_o) begin
        got_resp = 1;
        checks++;
        if (resp_err_o !== exp_err) begin failures++; $display("FAIL resp_err got=%b exp=%b", resp_err_o, exp_err); end
        if (exp_lat >= 0) begin
          checks++;
          if (cyc != exp_lat) begin failures++; $display("FAIL latency got=%0d exp=%0d", cyc, exp_lat); end
        end
        if (!we && !exp_err) begin
          checks++;
          if (resp_rdata_o !== exp_line) begin failures++; $display("FAIL resp_rdata got=%h exp=%h", resp_rdata_o, exp_line); end
        end
        if (we && last_rd_ok) begin
          checks++;
          if (resp_rdata_o !== last_rdata) begin failures++; $display("FAIL rdata_hold got=%h exp=%h", resp_rdata_o, last_rdata); end
        end
        if (!we) begin last_rd_ok = !exp_err; last_rdata = exp_line; end
      end else if (!addr_done) begin
        checks++;
        if (we) begin
          if ({m_axi_awvalid, m_axi_awaddr, m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst} !==
              {1'b1, exp_addr, AXI_ID, 8'd3, 3'd2, 2'b01}) begin
            failures++; $display("FAIL aw_phase got v=%b addr=%h len=%0d size=%0d burst=%b exp addr=%h len=3 size=2 burst=01",
                                 m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, exp_addr);
          end
        end else begin
          if ({m_axi_arvalid, m_axi_araddr, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst} !==
              {1'b1, exp_addr, AXI_ID, 8'd3, 3'd2, 2'b01}) begin
            failures++; $display("FAIL ar_phase got v=%b addr=%h len=%0d size=%0d burst=%b exp addr=%h len=3 size=2 burst=01",
                                 m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, exp_addr);
          end
        end
        if (a_wait == 0) begin
          if (we) m_axi_awready = 1; else m_axi_arready = 1;
          addr_done = 1;
        end else a_wait--;
      end else if (we && beat < BEATS) begin
        checks++;
        if ({m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast} !==
            {1'b1, line[beat*DATA_W +: DATA_W], {(DATA_W/8){1'b1}}, 1'(beat == BEATS - 1)}) begin
          failures++; $display("FAIL w_beat%0d got v=%b data=%h strb=%h last=%b exp data=%h last=%b", beat,
                               m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, line[beat*DATA_W +: DATA_W], beat == BEATS - 1);
        end
        if (beat == rst_beat) begin
          #2 rst_ni = 0;
          #1 checks++;
          if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, resp_valid_o, req_ready_o} !== 7'b0000001) begin
            failures++; $display("FAIL async_reset got aw=%b w=%b b=%b ar=%b r=%b resp=%b ready=%b exp all 0 ready=1",
                                 m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, resp_valid_o, req_ready_o);
          end
          req_valid_i = 0;
          repeat (2) @(negedge clk_i);
          rst_ni = 1;
          @(negedge clk_i);
          checks++;
          if ({req_ready_o, m_axi_wvalid, resp_valid_o} !== 3'b100) begin
            failures++; $display("FAIL post_reset_idle got ready=%b wvalid=%b resp=%b exp 1 0 0", req_ready_o, m_axi_wvalid, resp_valid_o);
          end
          done = 1; got_resp = 1;
        end else if (d_wait == 0) begin
          m_axi_wready = 1; beat++; d_wait = $urandom_range(0, stall);
        end else d_wait--;
      end else if (!data_done) begin
        if (we) begin
          m_axi_bvalid = 1; m_axi_bresp = bresp; m_axi_bid = rsp_id;
          checks++;
          if (m_axi_bready !== 1'b1) begin failures++; $display("FAIL bready got=%b exp=1", m_axi_bready); end
          data_done = 1;
        end else if (d_wait > 0) d_wait--;
        else begin
          m_axi_rvalid = 1; m_axi_rdata = rbeats[beat]; m_axi_rid = rsp_id;
          m_axi_rresp = (beat == bad_beat) ? 2'b11 : 2'b00;
          m_axi_rlast = (beat == rlast_beat);
          checks++;
          if (m_axi_rready !== 1'b1) begin failures++; $display("FAIL rready_beat%0d got=%b exp=1", beat, m_axi_rready); end
          beat++;
          if (beat == BEATS || m_axi_rlast) data_done = 1;
          d_wait = $urandom_range(0, stall);
        end
      end
    end
    clear_slave();
    req_valid_i = 0;
    if (!done) begin failures++; $display("FAIL timeout we=%b cycles=%0d", we, cyc); end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({req_ready_o, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, resp_valid_o, resp_err_o} !== 8'b1000_0000) begin
      failures++; $display("FAIL reset_ctrl got ready=%b aw=%b w=%b b=%b ar=%b r=%b resp=%b err=%b exp ready=1 others 0",
                           req_ready_o, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, resp_valid_o, resp_err_o);
    end
    checks++;
    if (resp_rdata_o !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata_o); end
    repeat (3) @(negedge clk_i);
    rst_ni = 1;
  endtask

  task automatic test_write_basic();
    run_txn(1, 32'h0000_101C, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
            0, 2'b00, AXI_ID, -1, BEATS - 1, 7, -1);
  endtask

  task automatic test_read_basic();
    run_txn(0, 32'h0000_2000, '0, 0, 2'b00, AXI_ID, -1, BEATS - 1, 6, -1);
  endtask

  task automatic test_random_stalls();
    for (int i = 0; i < 10; i++)
      run_txn(1'($urandom), $urandom, rand_line(), 5, 2'b00, AXI_ID, -1, BEATS - 1, -1, -1);
  endtask

  task automatic test_errors();
    run_txn(1, 32'h0000_3000, rand_line(), 0, 2'b10, AXI_ID, -1, BEATS - 1, 7, -1);
    run_txn(1, 32'h0000_3040, rand_line(), 2, 2'b00, 4'd5, -1, BEATS - 1, -1, -1);
    run_txn(0, 32'h0000_4000, '0, 0, 2'b00, AXI_ID, 2, BEATS - 1, 6, -1);
    run_txn(0, 32'h0000_4100, '0, 0, 2'b00, AXI_ID, -1, 1, 4, -1);
    run_txn(0, 32'h0000_4200, '0, 1, 2'b00, AXI_ID, -1, BEATS, -1, -1);
    run_txn(0, 32'h0000_4300, '0, 0, 2'b00, 4'd3, -1, BEATS - 1, 6, -1);
    run_txn(1, 32'h0000_5000, rand_line(), 0, 2'b00, AXI_ID, -1, BEATS - 1, 7, -1);
    run_txn(0, 32'h0000_5010, '0, 0, 2'b00, AXI_ID, -1, BEATS - 1, 6, -1);
  endtask

  task automatic test_reset_mid_burst();
    run_txn(1, 32'h0000_6000, rand_line(), 0, 2'b00, AXI_ID, -1, BEATS - 1, -1, 2);
    last_rd_ok = 1'b1; last_rdata = '0;
    run_txn(0, 32'h0000_6100, '0, 0, 2'b00, AXI_ID, -1, BEATS - 1, 6, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) run_txn(1, $urandom, rand_line(), 0, 2'b00, AXI_ID, -1, BEATS - 1, 7, -1);
      else            run_txn(0, $urandom, '0, 0, 2'b00, AXI_ID, -1, BEATS - 1, 6, -1);
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_random_stalls();
    test_errors();
    test_reset_mid_burst();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout reached");
    $fatal(1, "global timeout");
  end
endmodule
